// File: rtl/servo_pkg.sv
// Shared constants and helpers for the servo PWM timing blocks.
package servo_pkg;

  localparam int US_W    = 11;
  localparam int FRAME_W = 15;

  localparam int DEF_MIN_US    = 1000;
  localparam int DEF_MAX_US    = 2000;
  localparam int DEF_CENTER_US = 1500;
  localparam int DEF_FRAME_US  = 20000;

  function automatic logic [US_W-1:0] clamp_us(
    input logic [US_W-1:0] v,
    input logic [US_W-1:0] lo,
    input logic [US_W-1:0] hi
  );
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Divides clk down to a one-cycle strobe every DIV clocks (1 us at DIV = MHz).
module us_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("us_tick_gen: DIV must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// 50 Hz hobby-servo PWM with clamped target, per-frame slew limit and
// frame-boundary-only updates so no runt or stretched pulses appear.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FRAME_US    = DEF_FRAME_US,
  parameter int MIN_US      = DEF_MIN_US,
  parameter int MAX_US      = DEF_MAX_US,
  parameter int CENTER_US   = DEF_CENTER_US,
  parameter int SLEW_US     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [US_W-1:0] pulse_us,
  input  logic            pulse_valid,
  input  logic            enable,
  output logic            pwm,
  output logic            frame_start,
  output logic [US_W-1:0] cur_us
);

  localparam int DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int SW  = US_W + 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_US - 1);
  localparam logic [US_W-1:0]    MIN_V      = US_W'(MIN_US);
  localparam logic [US_W-1:0]    MAX_V      = US_W'(MAX_US);
  localparam logic [US_W-1:0]    CTR_V      = US_W'(CENTER_US);
  localparam logic [SW-1:0]      SLEW_V     = SW'(SLEW_US);

  if (DIV < 1 || (CLK_FREQ_HZ % 1_000_000) != 0) begin : g_bad_clk
    $error("servo_pwm_gen: CLK_FREQ_HZ must be a nonzero multiple of 1 MHz");
  end
  if (!(MIN_US <= CENTER_US && CENTER_US <= MAX_US && MAX_US < FRAME_US)) begin : g_bad_range
    $error("servo_pwm_gen: need MIN_US <= CENTER_US <= MAX_US < FRAME_US");
  end
  if (MAX_US >= 2048) begin : g_bad_max
    $error("servo_pwm_gen: MAX_US must fit in 11 bits");
  end
  if (FRAME_US >= 32768) begin : g_bad_frame
    $error("servo_pwm_gen: FRAME_US must fit in 15 bits");
  end
  if (SLEW_US < 0 || SLEW_US > MAX_US) begin : g_bad_slew
    $error("servo_pwm_gen: SLEW_US out of range");
  end

  logic                   us_tick;
  logic                   wrap;
  logic [FRAME_W-1:0]     us_cnt_q, us_cnt_d;
  logic [US_W-1:0]        target_q, target_d;
  logic [US_W-1:0]        cur_us_q, cur_us_d;
  logic                   en_q, en_d;
  logic                   pwm_q, pwm_d;
  logic                   frame_start_q, frame_start_d;
  logic signed [SW-1:0]   diff;
  logic [SW-1:0]          diff_mag;

  us_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (us_tick)
  );

  always_comb begin
    wrap     = us_tick && (us_cnt_q == FRAME_LAST);
    us_cnt_d = us_cnt_q;
    if (us_tick) us_cnt_d = wrap ? '0 : us_cnt_q + FRAME_W'(1);

    target_d = pulse_valid ? clamp_us(pulse_us, MIN_V, MAX_V) : target_q;

    // Slew uses the target held before this edge; a same-cycle strobe lands next frame.
    diff     = $signed({1'b0, target_q}) - $signed({1'b0, cur_us_q});
    diff_mag = diff[SW-1] ? $unsigned(-diff) : $unsigned(diff);

    cur_us_d = cur_us_q;
    en_d     = en_q;
    if (wrap) begin
      en_d = enable;
      if (SLEW_US == 0 || diff_mag <= SLEW_V) cur_us_d = target_q;
      else if (diff[SW-1])                    cur_us_d = cur_us_q - SLEW_V[US_W-1:0];
      else                                    cur_us_d = cur_us_q + SLEW_V[US_W-1:0];
    end

    frame_start_d = wrap;
    pwm_d         = en_q && (us_cnt_q < FRAME_W'(cur_us_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      us_cnt_q      <= '0;
      target_q      <= CTR_V;
      cur_us_q      <= CTR_V;
      en_q          <= 1'b0;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      us_cnt_q      <= us_cnt_d;
      target_q      <= target_d;
      cur_us_q      <= cur_us_d;
      en_q          <= en_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm         = pwm_q;
  assign frame_start = frame_start_q;
  assign cur_us      = cur_us_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Three servo_pwm_gen instances checked cycle-by-cycle against a frame-position
// reference model, plus table-driven and hand-written frame sequences.
module tb_servo_pwm_gen;

  localparam int N = 3;
  // u0: 4 MHz / 2500 us / slew 20, u1: 1 MHz / 2100 us / slew 0, u2: 1 MHz / 2050 us / slew 20
  localparam int M_DIV   [N] = '{4, 1, 1};
  localparam int M_FRAME [N] = '{2500, 2100, 2050};
  localparam int M_SLEW  [N] = '{20, 0, 20};

  logic        clk;
  logic        rst         [N];
  logic [10:0] pulse_us    [N];
  logic        pulse_valid [N];
  logic        enable      [N];
  logic        pwm         [N];
  logic        frame_start [N];
  logic [10:0] cur_us      [N];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 0;

  typedef struct {
    logic [10:0] pulse;
    int          exp_cur;
  } vec_t;
  vec_t tbl [9];

  servo_pwm_gen #(.CLK_FREQ_HZ(4_000_000), .FRAME_US(2500), .SLEW_US(20)) u0 (
    .clk(clk), .rst(rst[0]), .pulse_us(pulse_us[0]), .pulse_valid(pulse_valid[0]),
    .enable(enable[0]), .pwm(pwm[0]), .frame_start(frame_start[0]), .cur_us(cur_us[0]));
  servo_pwm_gen #(.CLK_FREQ_HZ(1_000_000), .FRAME_US(2100), .SLEW_US(0)) u1 (
    .clk(clk), .rst(rst[1]), .pulse_us(pulse_us[1]), .pulse_valid(pulse_valid[1]),
    .enable(enable[1]), .pwm(pwm[1]), .frame_start(frame_start[1]), .cur_us(cur_us[1]));
  servo_pwm_gen #(.CLK_FREQ_HZ(1_000_000), .FRAME_US(2050), .SLEW_US(20)) u2 (
    .clk(clk), .rst(rst[2]), .pulse_us(pulse_us[2]), .pulse_valid(pulse_valid[2]),
    .enable(enable[2]), .pwm(pwm[2]), .frame_start(frame_start[2]), .cur_us(cur_us[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: position within the frame in clocks since reset.
  int m_pos [N];
  int m_cur [N];
  int m_tgt [N];
  bit m_en  [N];
  bit e_pwm [N];
  bit e_fs  [N];

  function automatic int clamp_ref(int v);
    if (v < 1000) return 1000;
    if (v > 2000) return 2000;
    return v;
  endfunction

  function automatic int slew_ref(int cur, int tgt, int s);
    int d;
    d = tgt - cur;
    if (s == 0 || (d <= s && d >= -s)) return tgt;
    return (d > 0) ? cur + s : cur - s;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int fclk;
      fclk = M_DIV[i] * M_FRAME[i];
      if (rst[i]) begin
        m_pos[i] = 0; m_cur[i] = 1500; m_tgt[i] = 1500; m_en[i] = 0;
        e_pwm[i] = 0; e_fs[i] = 0;
      end else begin
        e_pwm[i] = m_en[i] && (m_pos[i] < m_cur[i] * M_DIV[i]);
        e_fs[i]  = (m_pos[i] + 1 == fclk);
        if (e_fs[i]) begin
          m_cur[i] = slew_ref(m_cur[i], m_tgt[i], M_SLEW[i]);
          m_en[i]  = enable[i];
        end
        if (pulse_valid[i]) m_tgt[i] = clamp_ref(int'(pulse_us[i]));
        m_pos[i] = (m_pos[i] + 1) % fclk;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("u%0d pwm", i), 32'(pwm[i]), 32'(e_pwm[i]));
        check($sformatf("u%0d frame_start", i), 32'(frame_start[i]), 32'(e_fs[i]));
        check($sformatf("u%0d cur_us", i), 32'(cur_us[i]), m_cur[i]);
        check($sformatf("u%0d cur_us in range", i),
              32'(cur_us[i] >= 11'd1000 && cur_us[i] <= 11'd2000), 1);
      end
    end
  end

  // Runs from the current negedge until the next frame_start (bounded by lim).
  task automatic run_frame(input int i, input int lim, input int pv_at, input logic [10:0] pv_val,
                           input int en_at, input logic en_val, output int hi, output int len);
    hi = 0; len = 0;
    do begin
      pulse_valid[i] = (len == pv_at);
      if (len == pv_at) pulse_us[i] = pv_val;
      if (len == en_at) enable[i] = en_val;
      hi += int'(pwm[i]);
      len++;
      @(negedge clk);
    end while (frame_start[i] !== 1'b1 && len < lim);
    pulse_valid[i] = 1'b0;
  endtask

  task automatic seq_u0();
    int hi, len;
    run_frame(0, 20000, -1, 0, -1, 1, hi, len);
    check("u0 frame0 high clks", hi, 0);
    check("u0 frame0 length", len, 10000);
    for (int f = 1; f <= 2; f++) begin
      run_frame(0, 20000, -1, 0, -1, 1, hi, len);
      check($sformatf("u0 frame%0d high clks", f), hi, 6000);
      check($sformatf("u0 frame%0d length", f), len, 10000);
    end
    // Mid-pulse: new target 2000 and enable drop; pulse must still complete.
    run_frame(0, 20000, 5000, 11'd2000, 5000, 1'b0, hi, len);
    check("u0 frame3 high clks", hi, 6000);
    check("u0 frame3 length", len, 10000);
    check("u0 cur after frame3", 32'(cur_us[0]), 1520);
    run_frame(0, 20000, -1, 0, 100, 1'b1, hi, len);
    check("u0 frame4 disabled high clks", hi, 0);
    check("u0 cur after frame4", 32'(cur_us[0]), 1540);
    hi = 0;
    for (int k = 0; k < 3000; k++) begin
      hi += int'(pwm[0]);
      @(negedge clk);
    end
    check("u0 frame5 pulse returned", hi, 2999);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("u0 pwm after reset", 32'(pwm[0]), 0);
    check("u0 frame_start after reset", 32'(frame_start[0]), 0);
    check("u0 cur after reset", 32'(cur_us[0]), 1500);
    run_frame(0, 20000, -1, 0, -1, 1, hi, len);
    check("u0 post-reset frame high clks", hi, 0);
    check("u0 post-reset frame length", len, 10000);
    check("u0 cur after post-reset frame", 32'(cur_us[1 - 1]), 1500);
  endtask

  task automatic seq_u1();
    int hi, len, prev;
    run_frame(1, 5000, -1, 0, -1, 1, hi, len);
    check("u1 frame0 high clks", hi, 0);
    prev = 1500;
    for (int v = 0; v < 9; v++) begin
      run_frame(1, 5000, 300, tbl[v].pulse, -1, 1, hi, len);
      check($sformatf("u1 vec%0d high clks", v), hi, prev);
      check($sformatf("u1 vec%0d length", v), len, 2100);
      check($sformatf("u1 vec%0d cur_us", v), 32'(cur_us[1]), tbl[v].exp_cur);
      prev = tbl[v].exp_cur;
    end
    // Strobe in the wrap cycle: applied one frame late.
    run_frame(1, 5000, 2099, 11'd1100, -1, 1, hi, len);
    check("u1 wrap-strobe old value", 32'(cur_us[1]), 1700);
    run_frame(1, 5000, -1, 0, -1, 1, hi, len);
    check("u1 wrap-strobe high clks", hi, 1700);
    check("u1 wrap-strobe new value", 32'(cur_us[1]), 1100);
    for (int k = 0; k < 31500; k++) begin
      pulse_valid[1] = ($urandom_range(0, 399) == 0);
      if (pulse_valid[1]) pulse_us[1] = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 2999) == 0) enable[1] = ~enable[1];
      @(negedge clk);
    end
    pulse_valid[1] = 1'b0;
  endtask

  task automatic seq_u2();
    int hi, len, exp_cur, prev;
    run_frame(2, 5000, -1, 0, -1, 1, hi, len);
    check("u2 frame0 high clks", hi, 0);
    run_frame(2, 5000, 100, 11'd2000, -1, 1, hi, len);
    check("u2 frame1 high clks", hi, 1500);
    check("u2 slew step1", 32'(cur_us[2]), 1520);
    prev = 1520;
    for (int k = 2; k <= 27; k++) begin
      run_frame(2, 5000, -1, 0, -1, 1, hi, len);
      exp_cur = (1500 + 20 * k > 2000) ? 2000 : 1500 + 20 * k;
      check($sformatf("u2 frame%0d high clks", k), hi, prev);
      check($sformatf("u2 slew step%0d", k), 32'(cur_us[2]), exp_cur);
      prev = exp_cur;
    end
    for (int k = 0; k < 6000; k++) begin
      pulse_valid[2] = ($urandom_range(0, 299) == 0);
      if (pulse_valid[2]) pulse_us[2] = ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 1999) == 0) enable[2] = ~enable[2];
      @(negedge clk);
    end
    pulse_valid[2] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; enable[i] = 1'b1; pulse_valid[i] = 1'b0; pulse_us[i] = 11'd1500;
    end
    tbl[0] = '{11'd0,    1000};
    tbl[1] = '{11'd1800, 1800};
    tbl[2] = '{11'd2047, 2000};
    tbl[3] = '{11'd500,  1000};
    tbl[4] = '{11'd1000, 1000};
    tbl[5] = '{11'd2000, 2000};
    tbl[6] = '{11'd999,  1000};
    tbl[7] = '{11'd2001, 2000};
    tbl[8] = '{11'd1700, 1700};
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    chk_on = 1'b1;
    fork
      seq_u0();
      seq_u1();
      seq_u2();
    join
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got still running required finished");
    $fatal(1);
  end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream stage of the steering path. Consumes a commanded servo pulse width in microseconds, e.g. the +1000-offset joystick value.
- Produces one standard 50 Hz hobby-servo PWM output.
- Adds clamping, per-frame slew limiting and glitch-free updates only at frame boundaries.
- One instance per servo channel (X-left, X-right, Y) inside the steering blocks.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency. Must be an integer multiple of 1_000_000.
- FRAME_US, 20000, PWM frame period in microseconds.
- MIN_US, 1000, minimum allowed pulse width (us).
- MAX_US, 2000, maximum allowed pulse width (us).
- CENTER_US, 1500, reset/neutral pulse width (us).
- SLEW_US, 20, maximum change of applied pulse width per frame (us); 0 = slew limiting disabled (jump directly).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pulse_us  in  11  commanded pulse width, microseconds, unsigned
- pulse_valid  in  1  single-cycle strobe; capture pulse_us as the new target
- enable  in  1  output enable, sampled at frame boundary
- pwm  out  1  servo PWM output
- frame_start  out  1  one-cycle strobe in the first cycle of each frame
- cur_us  out  11  pulse width applied in the current frame

Behaviour:
- Clocking and reset
  - Single clock domain.
  - Reset is synchronous and active-high: rst sampled high on a rising edge of clk resets all state.
- Reset values
  - pwm=0, frame_start=0, cur_us=CENTER_US, target=CENTER_US.
  - Prescaler=0, us_cnt=0, en_q=0.
- Microsecond tick
  - Prescaler counts 0..DIV-1, where DIV=CLK_FREQ_HZ/1_000_000.
  - us_tick=1 for one clk when prescaler==DIV-1, then prescaler wraps to 0.
- Frame counter
  - us_cnt (15 bit) increments on us_tick and wraps FRAME_US-1 -> 0.
  - Wrap event = us_tick && us_cnt==FRAME_US-1.
- Target capture
  - On pulse_valid: target <= clamp(pulse_us).
  - Clamp rule: below MIN_US -> MIN_US; above MAX_US -> MAX_US; otherwise pass through.
  - Capture is independent of frame timing; the last strobe before a wrap wins.
- Frame update, registered on the wrap event
  - d = target - cur_us (signed 12 bit).
  - If SLEW_US==0 or |d|<=SLEW_US: cur_us <= target.
  - Else: cur_us <= cur_us + SLEW_US when d>0, or cur_us - SLEW_US when d<0.
  - en_q <= enable.
- frame_start is high exactly in the cycle after the wrap event (first cycle with us_cnt=0). cur_us and en_q already hold their new values in that cycle.
- PWM output
  - pwm (registered) = en_q && (us_cnt < cur_us).
  - High time is exactly cur_us * DIV clocks; frame length is FRAME_US * DIV clocks.
  - Registering gives one clock of latency relative to us_cnt; this latency is constant.
- Glitch freedom
  - cur_us and en_q change only at the wrap event, so no runt or stretched pulses occur.
  - enable deassert mid-frame takes effect on the next frame; the current pulse completes.
- Boundary and corner cases
  - pulse_valid in the same cycle as the wrap event: the slew computation uses the OLD target; the new target is seen at the next wrap.
  - pulse_us=0 or 2047 clamps to MIN_US/MAX_US.
  - cur_us never leaves [MIN_US, MAX_US].
  - rst mid-frame or mid-pulse: pwm drops to 0 the next cycle and a fresh frame begins from us_cnt=0. The first frame after reset has pwm low (en_q=0).
- Compile-time checks (elaborate-time assertions):
  - MIN_US <= CENTER_US <= MAX_US < FRAME_US
  - MAX_US < 2048
  - FRAME_US < 32768

Decomposition:
- Shared package servo_pkg:
  - constants US_W=11 and FRAME_W=15
  - default MIN_US/MAX_US/CENTER_US/FRAME_US
  - function clamp_us()
- Sub-module us_tick_gen (parameter DIV; ports clk, rst, tick). It is reused by other timing blocks.
- Frame counter, slew logic and PWM compare stay in servo_pwm_gen.

Test Plan:
Bench override: CLK_FREQ_HZ=4_000_000 (DIV=4) and FRAME_US=2500; all other parameters at defaults.
1. Reset release, enable=1, no pulse_valid:
   - first frame pwm=0
   - every later frame pwm high exactly 1500*4=6000 clks, period exactly 10000 clks
   - frame_start one clk wide every 10000 clks
2. pulse_valid with pulse_us=2000 mid-frame 3:
   - current frame keeps 1500
   - cur_us then reads 1520, 1540, ... per frame, reaching 2000 after 25 frames and holding there
3. pulse_us=500, then pulse_us=2047 (separate strobes; wait for settle each):
   - targets clamp to 1000 and 2000 respectively
   - cur_us never outside [1000,2000]; pwm high time = cur_us*4 clks
4. Repeat with SLEW_US=0:
   - pulse_us=1800 -> cur_us=1800 on the very next frame_start, no intermediate values
   - pulse_valid coincident with the wrap cycle -> that frame uses the old value, the new one applies one frame later
5. enable 1->0 during a pwm-high phase:
   - the current pulse completes at full width
   - the next frame pwm=0
   - re-assert enable -> the pulse returns the frame after the next wrap
6. rst asserted for 1 clk mid-pulse:
   - pwm=0 next cycle, cur_us=1500, us_cnt restarts at 0
   - first post-reset frame pwm low; no frame_start during reset
